fifo_ring: RTL and testbench
============================

# fifo_ring

Parametrised round-robin FIFO built from DEPTH single-entry slots, the generalisation of the two-slot ping-pong FIFO used between request and indication paths. Enqueues rotate through slots via a write pointer and dequeues via a read pointer, so each slot sees at most one access per cycle. Adds occupancy count, programmable almost-full flag and a synchronous flush. Sits between a request method (enq) and a rule that drains it (deq/first), e.g. echo-style request/indication loops carrying wide payloads.

## Interface
- WIDTH, 704, payload width in bits (>=1)
- DEPTH, 4, number of slots (>=2; need not be a power of two)
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  asynchronous, active-low reset
- in$enq__ENA  in  1  enqueue strobe; legal only when in$enq__RDY=1
- in$enq$v  in  WIDTH  enqueue payload
- in$enq__RDY  out  1  slot at write pointer is empty
- out$deq__ENA  in  1  dequeue strobe; legal only when out$deq__RDY=1
- out$deq__RDY  out  1  slot at read pointer is full
- out$first  out  WIDTH  payload at read pointer; all-zero when out$first__RDY=0
- out$first__RDY  out  1  equal to out$deq__RDY
- flush__ENA  in  1  discard all contents
- flush__RDY  out  1  constant 1
- count  out  $clog2(DEPTH+1)  number of valid slots
- almost_full  out  1  count >= AF_LEVEL

## Operation
- State: per-slot valid bit and WIDTH data register; wptr, rptr in 0..DEPTH-1; count register.
- Pointer advance: p <= (p == DEPTH-1) ? 0 : p+1; no power-of-two assumption.
- enq (ENA & RDY): data[wptr] <= in$enq$v, valid[wptr] <= 1, wptr advances.
- deq (ENA & RDY): valid[rptr] <= 0, rptr advances; data register not cleared.
- enq and deq in same cycle: both take effect (different slots, since RDYs derive from registered state); count unchanged.
- count: +1 on enq only, -1 on deq only, unchanged on both/neither.
- All RDYs are functions of registered state only; no enq-to-first bypass, no deq-to-enq pass-through when full.
- flush__ENA: all valid <= 0, wptr <= 0, rptr <= 0, count <= 0; overrides a coincident enq and deq (both dropped, no error).
- ENA without RDY is a caller error; block ignores it (no state change) and the bench flags it.
- Ordering: strict FIFO; data leaves in enq order across pointer wrap.

## Timing
- Reset (nRST low, asynchronous): valid all 0, wptr=rptr=0, count=0; outputs in$enq__RDY=1, out$deq__RDY=0, out$first__RDY=0, out$first=0, almost_full=0 (AF_LEVEL>=1), flush__RDY=1. Data registers need not be reset.
- Reset deassertion mid-traffic: contents lost; first enq after release lands in slot 0.
- Enq-to-first latency: 1 cycle (enq at edge n, out$first__RDY=1 and out$first valid after edge n).
- Deq-to-enq-RDY when full: 1 cycle (deq at edge n frees slot; in$enq__RDY rises after edge n).
- Throughput: one enq and one deq per cycle sustained when 0 < count < DEPTH.
- Full: count=DEPTH, in$enq__RDY=0. Empty: count=0, out$deq__RDY=0, out$first=0.
- count and almost_full update on the same edge as the causing enq/deq/flush.

## Test plan
- Reset: hold nRST low 3 cycles -> in$enq__RDY=1, out$deq__RDY=0, count=0, out$first=0, almost_full=0.
- Fill/drain, DEPTH=4: enq 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4, almost_full rises at count 3, in$enq__RDY=0 at 4; deq x4 -> out$first 0x11,0x22,0x33,0x44 in order, count returns 0.
- Wrap and concurrent, DEPTH=3: enq A,B; then 10 cycles of simultaneous enq/deq with incrementing payload -> count stays 2, pointers wrap 2->0, output sequence strictly in enq order.
- Full boundary: fill DEPTH=4, assert deq with enq same cycle -> enq not RDY so only deq occurs, count 3; next cycle enq accepted, count 4.
- Flush: count=3, assert flush__ENA with enq__ENA and deq__ENA -> next cycle count=0, out$deq__RDY=0, wptr=rptr=0; subsequent enq 0x55 emerges first.
- Async reset mid-operation: count=2, pull nRST low between edges -> outputs reach reset values before next CLK edge; after release, enq 0x77 then deq returns 0x77.

Source files
------------

// File: rtl/fifo_ring.sv
// fifo_ring: round-robin FIFO of DEPTH single-entry slots.
// Enq rotates through slots via wptr, deq via rptr, so each slot sees at
// most one access per cycle. All RDYs come from registered state only.
// Flush overrides any coincident enq/deq.
module fifo_ring #(
  parameter int unsigned WIDTH    = 704,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       in_enq__ENA,
  input  logic [WIDTH-1:0]           in_enq_v,
  output logic                       in_enq__RDY,
  input  logic                       out_deq__ENA,
  output logic                       out_deq__RDY,
  output logic [WIDTH-1:0]           out_first,
  output logic                       out_first__RDY,
  input  logic                       flush__ENA,
  output logic                       flush__RDY,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            slot_vld;
  logic [DEPTH-1:0][WIDTH-1:0] slot_q;
  logic [PW-1:0]               wptr, rptr;
  logic                        enq_fire, deq_fire;

  // Pointer wrap without a power-of-two assumption.
  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_enq__RDY    = ~slot_vld[wptr];
  assign out_deq__RDY   = slot_vld[rptr];
  assign out_first__RDY = slot_vld[rptr];
  assign out_first      = slot_vld[rptr] ? slot_q[rptr] : '0;
  assign flush__RDY     = 1'b1;
  assign almost_full    = (count >= CW'(AF_LEVEL));

  // Strobes without RDY are ignored; flush drops both.
  assign enq_fire = in_enq__ENA  & in_enq__RDY  & ~flush__ENA;
  assign deq_fire = out_deq__ENA & out_deq__RDY & ~flush__ENA;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic wr, rd;
    assign wr = enq_fire && (wptr == PW'(i));
    assign rd = deq_fire && (rptr == PW'(i));

    // Slot valid bit: set on write, cleared on read or flush.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)           slot_vld[i] <= 1'b0;
      else if (flush__ENA) slot_vld[i] <= 1'b0;
      else if (wr)         slot_vld[i] <= 1'b1;
      else if (rd)         slot_vld[i] <= 1'b0;
    end

    // Slot payload: no reset, only written on enq; first is masked by valid.
    always_ff @(posedge CLK) begin
      if (wr) slot_q[i] <= in_enq_v;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush__ENA) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) wptr <= ptr_nxt(wptr);
      if (deq_fire) rptr <= ptr_nxt(rptr);
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ring.sv
// tb_fifo_ring: scoreboard bench for fifo_ring, DEPTH=4 and DEPTH=3 instances.
module tb_fifo_ring;

  localparam int W = 704;
  typedef logic [W-1:0] pl_t;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  // DEPTH=4 instance (AF_LEVEL=3)
  logic       enq4 = 1'b0, deq4 = 1'b0, fl4 = 1'b0;
  pl_t        v4 = '0;
  logic       enq_rdy4, deq_rdy4, first_rdy4, fl_rdy4, af4;
  pl_t        first4;
  logic [2:0] count4;

  // DEPTH=3 instance (AF_LEVEL=2)
  logic       enq3 = 1'b0, deq3 = 1'b0, fl3 = 1'b0;
  pl_t        v3 = '0;
  logic       enq_rdy3, deq_rdy3, first_rdy3, fl_rdy3, af3;
  pl_t        first3;
  logic [1:0] count3;

  fifo_ring #(.WIDTH(W), .DEPTH(4)) dut4 (
    .CLK(CLK), .nRST(nRST),
    .in_enq__ENA(enq4), .in_enq_v(v4), .in_enq__RDY(enq_rdy4),
    .out_deq__ENA(deq4), .out_deq__RDY(deq_rdy4),
    .out_first(first4), .out_first__RDY(first_rdy4),
    .flush__ENA(fl4), .flush__RDY(fl_rdy4),
    .count(count4), .almost_full(af4)
  );

  fifo_ring #(.WIDTH(W), .DEPTH(3)) dut3 (
    .CLK(CLK), .nRST(nRST),
    .in_enq__ENA(enq3), .in_enq_v(v3), .in_enq__RDY(enq_rdy3),
    .out_deq__ENA(deq3), .out_deq__RDY(deq_rdy3),
    .out_first(first3), .out_first__RDY(first_rdy3),
    .flush__ENA(fl3), .flush__RDY(fl_rdy3),
    .count(count3), .almost_full(af3)
  );

  int  vectors = 0;
  int  miscompares = 0;
  pl_t sb4[$];
  pl_t sb3[$];

  // One clock on the DEPTH=4 instance; returns 1 time unit after the edge.
  task automatic cyc4(input logic e, input pl_t v, input logic d, input logic f);
    enq4 = e; v4 = v; deq4 = d; fl4 = f;
    @(posedge CLK); #1;
    enq4 = 1'b0; deq4 = 1'b0; fl4 = 1'b0;
  endtask

  task automatic cyc3(input logic e, input pl_t v, input logic d);
    enq3 = e; v3 = v; deq3 = d; fl3 = 1'b0;
    @(posedge CLK); #1;
    enq3 = 1'b0; deq3 = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    vectors++;
    if (enq_rdy4 !== 1'b1 || deq_rdy4 !== 1'b0 || first_rdy4 !== 1'b0 ||
        count4 !== 3'd0 || first4 !== '0 || af4 !== 1'b0 || fl_rdy4 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset4: rdy e/d/f=%b%b%b cnt=%0d af=%b flr=%b first=%h; want 100 0 0 1 0",
               enq_rdy4, deq_rdy4, first_rdy4, count4, af4, fl_rdy4, first4);
    end
    vectors++;
    if (enq_rdy3 !== 1'b1 || deq_rdy3 !== 1'b0 || count3 !== 2'd0 || first3 !== '0 || af3 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset3: rdy e/d=%b%b cnt=%0d af=%b; want 10 0 0", enq_rdy3, deq_rdy3, count3, af3);
    end
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_fill_drain();
    pl_t exp;
    for (int i = 0; i < 4; i++) begin
      exp = pl_t'(32'h11 * (i + 1));
      sb4.push_back(exp);
      cyc4(1'b1, exp, 1'b0, 1'b0);
      vectors++;
      if (count4 !== 3'(i + 1) || af4 !== (i + 1 >= 3) || enq_rdy4 !== (i + 1 < 4) || first_rdy4 !== 1'b1) begin
        miscompares++;
        $display("FAIL fill[%0d]: cnt=%0d af=%b enq_rdy=%b first_rdy=%b; want cnt=%0d af=%b enq_rdy=%b first_rdy=1",
                 i, count4, af4, enq_rdy4, first_rdy4, i + 1, (i + 1 >= 3), (i + 1 < 4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp = sb4.pop_front();
      vectors++;
      if (first4 !== exp) begin
        miscompares++;
        $display("FAIL drain_first[%0d]: got %h want %h", i, first4[31:0], exp[31:0]);
      end
      cyc4(1'b0, '0, 1'b1, 1'b0);
      vectors++;
      if (count4 !== 3'(3 - i)) begin
        miscompares++;
        $display("FAIL drain_count[%0d]: got %0d want %0d", i, count4, 3 - i);
      end
    end
    vectors++;
    if (deq_rdy4 !== 1'b0 || first4 !== '0 || af4 !== 1'b0) begin
      miscompares++;
      $display("FAIL empty4: deq_rdy=%b af=%b first=%h; want 0 0 0", deq_rdy4, af4, first4[31:0]);
    end
  endtask

  task automatic test_wrap_concurrent();
    pl_t exp, nv;
    sb3.push_back(pl_t'(32'hA)); cyc3(1'b1, pl_t'(32'hA), 1'b0);
    sb3.push_back(pl_t'(32'hB)); cyc3(1'b1, pl_t'(32'hB), 1'b0);
    for (int k = 0; k < 10; k++) begin
      exp = sb3.pop_front();
      vectors++;
      if (first3 !== exp) begin
        miscompares++;
        $display("FAIL wrap_first[%0d]: got %h want %h", k, first3[31:0], exp[31:0]);
      end
      nv = pl_t'(32'h100 + k);
      sb3.push_back(nv);
      cyc3(1'b1, nv, 1'b1);
      vectors++;
      if (count3 !== 2'd2 || af3 !== 1'b1) begin
        miscompares++;
        $display("FAIL wrap_count[%0d]: cnt=%0d af=%b want 2 1", k, count3, af3);
      end
    end
    while (sb3.size() > 0) begin
      exp = sb3.pop_front();
      vectors++;
      if (first3 !== exp) begin
        miscompares++;
        $display("FAIL wrap_tail: got %h want %h", first3[31:0], exp[31:0]);
      end
      cyc3(1'b0, '0, 1'b1);
    end
    vectors++;
    if (count3 !== 2'd0 || deq_rdy3 !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_empty: cnt=%0d deq_rdy=%b want 0 0", count3, deq_rdy3);
    end
  endtask

  task automatic test_full_boundary();
    pl_t exp;
    for (int i = 1; i <= 4; i++) begin
      sb4.push_back(pl_t'(i));
      cyc4(1'b1, pl_t'(i), 1'b0, 1'b0);
    end
    vectors++;
    if (enq_rdy4 !== 1'b0 || count4 !== 3'd4) begin
      miscompares++;
      $display("FAIL full: enq_rdy=%b cnt=%0d want 0 4", enq_rdy4, count4);
    end
    // Model says full: this enq is a deliberate caller error and must be dropped.
    $display("note: caller error, enq strobe without RDY driven on purpose");
    exp = sb4.pop_front();
    vectors++;
    if (first4 !== exp) begin
      miscompares++;
      $display("FAIL full_first: got %h want %h", first4[31:0], exp[31:0]);
    end
    cyc4(1'b1, pl_t'(32'hDEAD), 1'b1, 1'b0);
    vectors++;
    if (count4 !== 3'd3 || enq_rdy4 !== 1'b1) begin
      miscompares++;
      $display("FAIL full_deq_only: cnt=%0d enq_rdy=%b want 3 1", count4, enq_rdy4);
    end
    sb4.push_back(pl_t'(5));
    cyc4(1'b1, pl_t'(5), 1'b0, 1'b0);
    vectors++;
    if (count4 !== 3'd4) begin
      miscompares++;
      $display("FAIL full_refill: cnt=%0d want 4", count4);
    end
    while (sb4.size() > 0) begin
      exp = sb4.pop_front();
      vectors++;
      if (first4 !== exp) begin
        miscompares++;
        $display("FAIL full_order: got %h want %h", first4[31:0], exp[31:0]);
      end
      cyc4(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_flush();
    pl_t exp;
    for (int i = 0; i < 3; i++) cyc4(1'b1, pl_t'(32'h61 + i), 1'b0, 1'b0);
    vectors++;
    if (count4 !== 3'd3) begin
      miscompares++;
      $display("FAIL flush_pre: cnt=%0d want 3", count4);
    end
    cyc4(1'b1, pl_t'(32'h64), 1'b1, 1'b1);
    vectors++;
    if (count4 !== 3'd0 || deq_rdy4 !== 1'b0 || first4 !== '0 || enq_rdy4 !== 1'b1 || af4 !== 1'b0) begin
      miscompares++;
      $display("FAIL flush: cnt=%0d deq_rdy=%b enq_rdy=%b af=%b first=%h want 0 0 1 0 0",
               count4, deq_rdy4, enq_rdy4, af4, first4[31:0]);
    end
    for (int i = 0; i < 4; i++) begin
      sb4.push_back(pl_t'(32'h55 + i));
      cyc4(1'b1, pl_t'(32'h55 + i), 1'b0, 1'b0);
    end
    while (sb4.size() > 0) begin
      exp = sb4.pop_front();
      vectors++;
      if (first4 !== exp) begin
        miscompares++;
        $display("FAIL flush_after: got %h want %h", first4[31:0], exp[31:0]);
      end
      cyc4(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    cyc4(1'b1, pl_t'(32'h91), 1'b0, 1'b0);
    cyc4(1'b1, pl_t'(32'h92), 1'b0, 1'b0);
    vectors++;
    if (count4 !== 3'd2) begin
      miscompares++;
      $display("FAIL areset_pre: cnt=%0d want 2", count4);
    end
    #2 nRST = 1'b0;
    #1;
    vectors++;
    if (count4 !== 3'd0 || deq_rdy4 !== 1'b0 || first_rdy4 !== 1'b0 || enq_rdy4 !== 1'b1 || first4 !== '0) begin
      miscompares++;
      $display("FAIL areset_mid: cnt=%0d deq_rdy=%b first_rdy=%b enq_rdy=%b first=%h want 0 0 0 1 0",
               count4, deq_rdy4, first_rdy4, enq_rdy4, first4[31:0]);
    end
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    cyc4(1'b1, pl_t'(32'h77), 1'b0, 1'b0);
    vectors++;
    if (first4 !== pl_t'(32'h77) || count4 !== 3'd1) begin
      miscompares++;
      $display("FAIL areset_after: first=%h cnt=%0d want 77 1", first4[31:0], count4);
    end
    cyc4(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (count4 !== 3'd0 || deq_rdy4 !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_drain: cnt=%0d deq_rdy=%b want 0 0", count4, deq_rdy4);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap_concurrent();
    test_full_boundary();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
